// File: rtl/gpioemu_host.sv
// Bus initiator for the gpioemu multiplier/popcount peripheral: writes operands, starts, polls, reads results.
// Optional poll timeout is built when GPIOEMU_HOST_TIMEOUT_EN is defined.
module gpioemu_host #(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned POLL_GAP      = 4,
    parameter int unsigned POLL_LIMIT    = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_a,
    input  logic [23:0] cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_w,
    output logic [23:0] rsp_l,
    output logic        rsp_err,
    output logic        busy,
    output logic [15:0] saddress,
    output logic        swr,
    output logic        srd,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);

    if (STROBE_CYCLES < 1 || POLL_LIMIT < 1) begin : g_bad_param
        $error("gpioemu_host: STROBE_CYCLES and POLL_LIMIT must be >= 1");
    end

    localparam int unsigned PH_MAX = (STROBE_CYCLES + 1 > POLL_GAP) ? STROBE_CYCLES + 1 : POLL_GAP;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    typedef logic [PH_W-1:0] ph_t;
    localparam ph_t PH_LAST_STB = ph_t'(STROBE_CYCLES);
    localparam ph_t PH_HOLD     = ph_t'(STROBE_CYCLES + 1);
    localparam ph_t PH_GAP_END  = ph_t'((POLL_GAP == 0) ? 0 : POLL_GAP - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_A, S_WR_B, S_WR_GO, S_POLL, S_POLL_WAIT, S_RD_W, S_RD_L, S_RESP
    } state_e;

    state_e      state_q, state_d;
    ph_t         phase_q, phase_d;
    logic [23:0] a_q, a_d, b_q, b_d;
    logic [1:0]  status_q, status_d;
    logic [31:0] rsp_w_q, rsp_w_d;
    logic [23:0] rsp_l_q, rsp_l_d;
    logic [15:0] saddress_q, saddress_d;
    logic [31:0] sdata_q, sdata_d;
    logic        swr_q, swr_d, srd_q, srd_d;
    logic        bus_wr, bus_rd, strobe_on;

`ifdef GPIOEMU_HOST_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(POLL_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(POLL_LIMIT);
    logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        a_d      = a_q;
        b_d      = b_q;
        status_d = status_q;
        rsp_w_d  = rsp_w_q;
        rsp_l_d  = rsp_l_q;
`ifdef GPIOEMU_HOST_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
        err_d      = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    rsp_w_d = '0;
                    rsp_l_d = '0;
`ifdef GPIOEMU_HOST_TIMEOUT_EN
                    poll_cnt_d = '0;
                    err_d      = 1'b0;
`endif
                    phase_d = '0;
                    state_d = S_WR_A;
                end
            end
            S_WR_A, S_WR_B, S_WR_GO, S_POLL, S_RD_W, S_RD_L: begin
                phase_d = phase_q + 1'b1;
                if (phase_q == PH_LAST_STB) begin
                    if (state_q == S_POLL) status_d = sdata_in[1:0];
                    if (state_q == S_RD_W) rsp_w_d = sdata_in;
                    if (state_q == S_RD_L) rsp_l_d = sdata_in[23:0];
                end
                if (phase_q == PH_HOLD) begin
                    phase_d = '0;
                    case (state_q)
                        S_WR_A:  state_d = S_WR_B;
                        S_WR_B:  state_d = S_WR_GO;
                        S_WR_GO: state_d = S_POLL;
                        S_RD_W:  state_d = S_RD_L;
                        S_RD_L:  state_d = S_RESP;
                        S_POLL: begin
                            // status_q was captured on the last strobe cycle of this access
                            if (status_q == 2'b11) begin
                                state_d = S_RD_W;
                            end else begin
                                state_d = (POLL_GAP == 0) ? S_POLL : S_POLL_WAIT;
`ifdef GPIOEMU_HOST_TIMEOUT_EN
                                poll_cnt_d = poll_cnt_q + 1'b1;
                                if (poll_cnt_d == CNT_LIMIT) begin
                                    state_d = S_RESP;
                                    err_d   = 1'b1;
                                end
`endif
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_POLL_WAIT: begin
                if (phase_q == PH_GAP_END) begin
                    phase_d = '0;
                    state_d = S_POLL;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Bus outputs are registered, so they are decoded from the next state/phase.
        saddress_d = saddress_q;
        sdata_d    = sdata_q;
        bus_wr     = 1'b0;
        bus_rd     = 1'b0;
        case (state_d)
            S_WR_A:  begin saddress_d = 16'h0380; sdata_d = {8'h00, a_d}; bus_wr = 1'b1; end
            S_WR_B:  begin saddress_d = 16'h0388; sdata_d = {8'h00, b_d}; bus_wr = 1'b1; end
            S_WR_GO: begin saddress_d = 16'h03A0; sdata_d = '0;           bus_wr = 1'b1; end
            S_POLL:  begin saddress_d = 16'h03A0; sdata_d = '0;           bus_rd = 1'b1; end
            S_RD_W:  begin saddress_d = 16'h0390; sdata_d = '0;           bus_rd = 1'b1; end
            S_RD_L:  begin saddress_d = 16'h0398; sdata_d = '0;           bus_rd = 1'b1; end
            default: ;
        endcase
        strobe_on = (phase_d != '0) && (phase_d <= PH_LAST_STB);
        swr_d     = bus_wr && strobe_on;
        srd_d     = bus_rd && strobe_on;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            status_q   <= '0;
            rsp_w_q    <= '0;
            rsp_l_q    <= '0;
            saddress_q <= '0;
            sdata_q    <= '0;
            swr_q      <= 1'b0;
            srd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            a_q        <= a_d;
            b_q        <= b_d;
            status_q   <= status_d;
            rsp_w_q    <= rsp_w_d;
            rsp_l_q    <= rsp_l_d;
            saddress_q <= saddress_d;
            sdata_q    <= sdata_d;
            swr_q      <= swr_d;
            srd_q      <= srd_d;
        end
    end

`ifdef GPIOEMU_HOST_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            poll_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
            err_q      <= err_d;
        end
    end
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_w     = rsp_w_q;
    assign rsp_l     = rsp_l_q;
    assign saddress  = saddress_q;
    assign sdata_out = sdata_q;
    assign swr       = swr_q;
    assign srd       = srd_q;

endmodule

// File: tb/tb_gpioemu_host.sv
// Bench for gpioemu_host: register-level peripheral responder, bus protocol monitor, directed and random jobs.
module tb_gpioemu_host;
    localparam int unsigned S = 2;
    localparam int unsigned G = 4;
`ifdef GPIOEMU_HOST_TIMEOUT_EN
    localparam int unsigned LIM = 4;
    localparam bit          TMO = 1'b1;
`else
    localparam int unsigned LIM = 64;
    localparam bit          TMO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [23:0] cmd_a = '0;
    logic [23:0] cmd_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_w;
    logic [23:0] rsp_l;
    logic        rsp_err;
    logic        busy;
    logic [15:0] saddress;
    logic        swr;
    logic        srd;
    logic [31:0] sdata_out;
    logic [31:0] sdata_in;

    gpioemu_host #(.STROBE_CYCLES(S), .POLL_GAP(G), .POLL_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_w(rsp_w), .rsp_l(rsp_l),
        .rsp_err(rsp_err), .busy(busy),
        .saddress(saddress), .swr(swr), .srd(srd), .sdata_out(sdata_out), .sdata_in(sdata_in)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Peripheral responder: registers written on strobe rise, status ready after ready_on polls.
    logic [23:0] m_a = '0;
    logic [23:0] m_b = '0;
    int          polls_seen = 0;
    int          ready_on = 1;
    logic [47:0] m_prod;
    assign m_prod = {24'h0, m_a} * {24'h0, m_b};

    always_comb begin
        sdata_in = 32'hDEAD_BEEF;
        case (saddress)
            16'h03A0: sdata_in = (polls_seen >= ready_on) ? 32'h3 : 32'h1;
            16'h0390: sdata_in = m_prod[31:0];
            16'h0398: sdata_in = {8'hA5, 24'($countones(m_prod[31:0]))};
            default:  ;
        endcase
    end

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [31:0] data;
    } op_t;
    op_t log_q[$];

    logic        st;
    assign st = srd | swr;
    logic [15:0] pa = '0;
    logic [31:0] pd = '0;
    bit          pst = 1'b0;
    int          hl = 0;

    always @(negedge clk) begin
        if (reset) begin
            pst <= 1'b0;
            hl  <= 0;
        end else begin
            if (st) chk("strobe_exclusive", 64'(srd & swr), 64'd0);
            if (srd) chk("read_sdata_zero", 64'(sdata_out), 64'd0);
            if (st || pst) chk("addr_data_stable", {16'h0, saddress, sdata_out}, {16'h0, pa, pd});
            if (st && !pst) begin
                log_q.push_back('{wr: swr, addr: saddress, data: sdata_out});
                if (swr && saddress == 16'h0380) m_a <= sdata_out[23:0];
                if (swr && saddress == 16'h0388) m_b <= sdata_out[23:0];
                if (swr && saddress == 16'h03A0) polls_seen <= 0;
                if (srd && saddress == 16'h03A0) polls_seen <= polls_seen + 1;
                hl <= 1;
            end else if (st) begin
                hl <= hl + 1;
            end
            if (!st && pst) chk("strobe_length", 64'(hl), 64'(S));
            pst <= st;
        end
        pa <= saddress;
        pd <= sdata_out;
    end

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({pfx, "_rsp_w"}, 64'(rsp_w), 64'd0);
        chk({pfx, "_rsp_l"}, 64'(rsp_l), 64'd0);
        chk({pfx, "_rsp_err"}, 64'(rsp_err), 64'd0);
        chk({pfx, "_busy"}, 64'(busy), 64'd0);
        chk({pfx, "_saddress"}, 64'(saddress), 64'd0);
        chk({pfx, "_strobes"}, 64'({swr, srd}), 64'd0);
        chk({pfx, "_sdata_out"}, 64'(sdata_out), 64'd0);
    endtask

    task automatic start_job(input logic [23:0] a, input logic [23:0] b, input int rdy, output int lat);
        for (int i = 0; i < 2000 && !cmd_ready; i++) @(negedge clk);
        chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        ready_on  = rdy;
        log_q.delete();
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        chk("busy_after_accept", 64'({cmd_ready, busy}), 64'b01);
    endtask

    task automatic finish_job(input logic [23:0] a, input logic [23:0] b, input int rdy,
                              input int bp, input int lat_in);
        bit          err = TMO && (rdy > int'(LIM));
        int          p = err ? int'(LIM) : rdy;
        int          exp_lat = (p + (err ? 3 : 5)) * int'(S + 2) + (p - 1) * int'(G) + 1;
        int          lat = lat_in;
        logic [47:0] prod = {24'h0, a} * {24'h0, b};
        logic [31:0] exp_w = err ? 32'h0 : prod[31:0];
        logic [23:0] exp_l = err ? 24'h0 : 24'($countones(prod[31:0]));
        int          n_stat = 0;
        int          n_res = 0;
        int          n_log;

        while (!rsp_valid && lat < exp_lat + 100) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_valid_seen", 64'(rsp_valid), 64'd1);
        chk("accept_to_rsp_cycles", 64'(lat), 64'(exp_lat));
        chk("rsp_w", 64'(rsp_w), 64'(exp_w));
        chk("rsp_l", 64'(rsp_l), 64'(exp_l));
        chk("rsp_err", 64'(rsp_err), 64'(err));
        chk("write_a", {log_q[0].wr, 15'h0, log_q[0].addr, log_q[0].data}, {1'b1, 15'h0, 16'h0380, 8'h00, a});
        chk("write_b", {log_q[1].wr, 15'h0, log_q[1].addr, log_q[1].data}, {1'b1, 15'h0, 16'h0388, 8'h00, b});
        chk("write_go", {log_q[2].wr, 15'h0, log_q[2].addr, log_q[2].data}, {1'b1, 15'h0, 16'h03A0, 32'h0});
        foreach (log_q[i]) begin
            if (!log_q[i].wr && log_q[i].addr == 16'h03A0) n_stat++;
            if (!log_q[i].wr && (log_q[i].addr == 16'h0390 || log_q[i].addr == 16'h0398)) n_res++;
        end
        chk("status_reads", 64'(n_stat), 64'(p));
        chk("result_reads", 64'(n_res), err ? 64'd0 : 64'd2);

        n_log = log_q.size();
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("backpressure_hold", {rsp_valid, rsp_err, cmd_ready, busy, srd, swr, 2'b00, rsp_l, rsp_w},
                {1'b1, err, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, exp_l, exp_w});
        end
        chk("backpressure_no_bus", 64'(log_q.size()), 64'(n_log));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("after_handshake", 64'({rsp_valid, cmd_ready, busy}), 64'b010);
    endtask

    task automatic run_job(input logic [23:0] a, input logic [23:0] b, input int rdy, input int bp);
        int lat;
        start_job(a, b, rdy, lat);
        finish_job(a, b, rdy, bp, lat);
    endtask

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        reset = 1'b0;
        @(negedge clk);

        run_job(24'd3, 24'd5, 2, 10);
        run_job(24'hFFFFFF, 24'hFFFFFF, 1, 0);
        for (int i = 0; i < 6; i++)
            run_job(24'($urandom), 24'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));

        if (TMO) run_job(24'd7, 24'd9, 1000000, 2);
        else     run_job(24'd7, 24'd9, 105, 2);

        start_job(24'h000123, 24'h000456, 1, lat);
        for (int i = 0; i < 40 && !(swr && saddress == 16'h0388); i++) @(negedge clk);
        chk("reached_wr_b_strobe", 64'(swr && saddress == 16'h0388), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_state("midjob_reset");
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", 64'({cmd_ready, rsp_valid, busy}), 64'b100);
        run_job(24'h00ABCD, 24'h000321, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
